// File: rtl/mem_req_sched.sv
// mem_req_sched: round-robin scheduler that shares one memory request port
// between several cache requesters. It allocates transaction IDs from a small
// pool, caps outstanding writes and routes each response back to the
// requester that issued it.
//
// Handshake: a transfer happens on a port in the cycle where its valid and
// ready are both 1. Valid never waits for ready. A requester holds its
// payload while valid is 1 and ready is 0. req_ready_o is one-hot or zero.
// The memory side is the same: mem_req_valid_o and the payload stay stable
// until mem_req_ready_i is 1. Responses have no ready and are always taken.
module mem_req_sched #(
  parameter int unsigned NrReq            = 3,
  parameter int unsigned AddrWidth        = 64,
  parameter int unsigned DataWidth        = 64,
  parameter int unsigned TidWidth         = 2,
  parameter int unsigned MaxWrOutstanding = 7
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NrReq-1:0]           req_valid_i,
  output logic [NrReq-1:0]           req_ready_o,
  input  logic [NrReq*AddrWidth-1:0] req_addr_i,
  input  logic [NrReq-1:0]           req_we_i,
  input  logic [NrReq*DataWidth-1:0] req_wdata_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [AddrWidth-1:0]       mem_req_addr_o,
  output logic                       mem_req_we_o,
  output logic [DataWidth-1:0]       mem_req_wdata_o,
  output logic [TidWidth-1:0]        mem_req_tid_o,
  input  logic                       mem_rsp_valid_i,
  input  logic [TidWidth-1:0]        mem_rsp_tid_i,
  output logic [NrReq-1:0]           rsp_valid_o,
  output logic [TidWidth-1:0]        rsp_tid_o,
  output logic                       spurious_rsp_o
);

  localparam int unsigned NrTid = 1 << TidWidth;
  localparam int unsigned SrcW  = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam int unsigned CntW  = $clog2(MaxWrOutstanding + 1);

  // Output stage
  logic                 out_valid_q;
  logic [AddrWidth-1:0] out_addr_q;
  logic                 out_we_q;
  logic [DataWidth-1:0] out_wdata_q;
  logic [TidWidth-1:0]  out_tid_q;

  // ID pool bookkeeping
  logic [NrTid-1:0] busy_q, busy_d;
  logic [NrTid-1:0] we_tbl_q, we_tbl_d;
  logic [SrcW-1:0]  src_tbl_q [NrTid];
  logic [SrcW-1:0]  src_tbl_d [NrTid];
  logic             free_found;
  logic [TidWidth-1:0] free_tid;

  // Arbitration
  logic [SrcW-1:0]  rr_q, rr_d;
  logic [NrReq-1:0] eligible;
  logic             grant_valid;
  logic [SrcW-1:0]  grant_idx;
  logic [SrcW:0]    cand;
  logic             loadable;
  logic             accept;

  // Write accounting and responses
  logic [CntW-1:0] wr_cnt_q;
  logic            wr_room;
  logic            wr_inc;
  logic            wr_dec;
  logic            rsp_busy;
  logic            rsp_hit;

  assign loadable = !out_valid_q || mem_req_ready_i;
  assign wr_room  = wr_cnt_q < CntW'(MaxWrOutstanding);
  assign rsp_busy = busy_q[mem_rsp_tid_i];
  assign rsp_hit  = mem_rsp_valid_i && rsp_busy;
  // Reset gating keeps the handshake outputs quiet while the pool is cleared.
  assign accept   = grant_valid && loadable && rst_ni;
  assign wr_inc   = accept && req_we_i[grant_idx];
  assign wr_dec   = rsp_hit && we_tbl_q[mem_rsp_tid_i];

  assign mem_req_valid_o = out_valid_q;
  assign mem_req_addr_o  = out_addr_q;
  assign mem_req_we_o    = out_we_q;
  assign mem_req_wdata_o = out_wdata_q;
  assign mem_req_tid_o   = out_tid_q;
  assign rsp_tid_o       = mem_rsp_tid_i;
  assign spurious_rsp_o  = mem_rsp_valid_i && !rsp_busy && rst_ni;

  // Lowest-index free ID from the registered busy bits (scan high to low so
  // the lowest free index is the last to be written).
  always_comb begin
    free_found = 1'b0;
    free_tid   = '0;
    for (int t = NrTid - 1; t >= 0; t--) begin
      if (!busy_q[t]) begin
        free_found = 1'b1;
        free_tid   = TidWidth'(t);
      end
    end
  end

  // A requester may compete only if an ID is free and, for writes, the cap allows it.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NrReq; i++) begin
      eligible[i] = req_valid_i[i] && free_found && (!req_we_i[i] || wr_room);
    end
  end

  // Round-robin pick: first eligible requester at or after rr_q, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NrReq; k++) begin
      cand = (SrcW+1)'(rr_q) + (SrcW+1)'(k);
      if (cand >= (SrcW+1)'(NrReq)) begin
        cand = cand - (SrcW+1)'(NrReq);
      end
      if (!grant_valid && eligible[cand[SrcW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[SrcW-1:0];
      end
    end
  end

  // One-hot accept to the winner, only when the output stage can take it.
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Route a response for a busy ID to its recorded source.
  always_comb begin
    rsp_valid_o = '0;
    if (rsp_hit) begin
      rsp_valid_o[src_tbl_q[mem_rsp_tid_i]] = 1'b1;
    end
  end

  // Next pool state: free on response, allocate on accept. The allocated ID
  // was free in busy_q, so it can never be the ID freed in the same cycle.
  always_comb begin
    busy_d    = busy_q;
    we_tbl_d  = we_tbl_q;
    src_tbl_d = src_tbl_q;
    rr_d      = rr_q;
    if (rsp_hit) begin
      busy_d[mem_rsp_tid_i] = 1'b0;
    end
    if (accept) begin
      busy_d[free_tid]    = 1'b1;
      we_tbl_d[free_tid]  = req_we_i[grant_idx];
      src_tbl_d[free_tid] = grant_idx;
      rr_d = (grant_idx == SrcW'(NrReq - 1)) ? '0 : grant_idx + SrcW'(1);
    end
  end

  // Output stage register: load on accept, drain when downstream takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_we_q    <= 1'b0;
      out_wdata_q <= '0;
      out_tid_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= req_addr_i[grant_idx*AddrWidth +: AddrWidth];
      out_we_q    <= req_we_i[grant_idx];
      out_wdata_q <= req_wdata_i[grant_idx*DataWidth +: DataWidth];
      out_tid_q   <= free_tid;
    end else if (mem_req_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  // ID pool, source table, round-robin pointer and write count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= '0;
      we_tbl_q <= '0;
      rr_q     <= '0;
      wr_cnt_q <= '0;
      for (int t = 0; t < NrTid; t++) begin
        src_tbl_q[t] <= '0;
      end
    end else begin
      busy_q    <= busy_d;
      we_tbl_q  <= we_tbl_d;
      src_tbl_q <= src_tbl_d;
      rr_q      <= rr_d;
      if (wr_inc && !wr_dec) begin
        wr_cnt_q <= wr_cnt_q + CntW'(1);
      end else if (wr_dec && !wr_inc) begin
        wr_cnt_q <= wr_cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: doc/mem_req_sched.md
# mem_req_sched

Memory-request scheduler for the write-through data-cache subsystem. It shares the single memory request port between the instruction-cache refill, data-cache miss refill and write-buffer drain requesters using round-robin arbitration. It also allocates transaction IDs, caps outstanding writes, and routes each response back to its originator. It sits between the cache controllers and the NoC/AXI adapter.

## Interface
- NrReq, 3, number of requesters (0 = icache, 1 = dcache miss, 2 = write buffer)
- AddrWidth, 64, request address width
- DataWidth, 64, write-data width
- TidWidth, 2, transaction ID width; 2**TidWidth IDs in the pool
- MaxWrOutstanding, 7, maximum writes in flight (issued, not yet responded)

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NrReq  per-requester request valid
- req_ready_o  out  NrReq  per-requester accept (one-hot or zero)
- req_addr_i  in  NrReq*AddrWidth  packed addresses, requester i at [i*AddrWidth +: AddrWidth]
- req_we_i  in  NrReq  1 = write
- req_wdata_i  in  NrReq*DataWidth  packed write data
- mem_req_valid_o  out  1  registered request valid
- mem_req_ready_i  in  1  downstream accept
- mem_req_addr_o  out  AddrWidth  registered address
- mem_req_we_o  out  1  registered write flag
- mem_req_wdata_o  out  DataWidth  registered write data
- mem_req_tid_o  out  TidWidth  allocated transaction ID
- mem_rsp_valid_i  in  1  response valid (always accepted)
- mem_rsp_tid_i  in  TidWidth  response ID
- rsp_valid_o  out  NrReq  one-hot response routing, combinational from mem_rsp_valid_i
- rsp_tid_o  out  TidWidth  passthrough of mem_rsp_tid_i
- spurious_rsp_o  out  1  single-cycle pulse on a response to a free ID

## Operation
- **Output stage.** One-entry register (valid, addr, we, wdata, tid). It is "loadable" when empty, or when it holds valid data and mem_req_ready_i = 1 in that cycle.
- **Eligibility.** A requester is eligible when req_valid_i is 1 and both of the following hold:
  - at least one ID is free;
  - if req_we_i = 1, the write count is below MaxWrOutstanding.
- **Arbitration.** Round-robin over eligible requesters, starting at pointer rr_q. The winner gets req_ready_o = 1 only when the stage is loadable. Losers and ineligible requesters see 0.
- **On accept (valid & ready).**
  - Load the output register.
  - Allocate the lowest-index free ID: mark it busy and record the source index in src_tbl[tid].
  - Set rr_q to winner+1, wrapping NrReq-1 to 0.
  - Increment the write count if this is a write.
- **Response.** If mem_rsp_valid_i = 1 and ID mem_rsp_tid_i is busy:
  - drive rsp_valid_o[src_tbl[tid]] = 1;
  - free the ID at the clock edge;
  - decrement the write count if that ID was a write (per-ID we bit stored).
- **Spurious response.** If the ID is free: rsp_valid_o = 0, spurious_rsp_o = 1 for that cycle, no state change.
- **Same-cycle free and allocate.** A freed ID becomes allocatable from the next cycle only; the allocator sees registered busy bits. Write increment and decrement in the same cycle leave the count unchanged.
- **Requester rule.** Requesters must hold addr/we/wdata stable while valid and not ready. The block does not check this.
- **Reset mid-operation.** All in-flight IDs are discarded. Responses arriving after reset are flagged spurious.

## Timing
- **Reset values.**
  - Outputs: mem_req_valid_o = 0, mem_req_addr_o = 0, mem_req_we_o = 0, mem_req_wdata_o = 0, mem_req_tid_o = 0, req_ready_o = 0, rsp_valid_o = 0, spurious_rsp_o = 0.
  - State: rr_q = 0, all IDs free, write count = 0.
- **Latency.** Accept in cycle N gives mem_req_valid_o = 1 in cycle N+1.
- **Throughput.** One request per cycle while mem_req_ready_i = 1 and IDs are available.
- **Stall.** mem_req_valid_o and its payload stay stable until mem_req_ready_i = 1.
- **Response path.** rsp_valid_o and spurious_rsp_o are combinational from the response inputs, with zero latency. The ID is free one cycle later.
- **ID exhaustion.** With 2**TidWidth IDs busy, req_ready_o = 0 for all requesters. The first allocation after a free lands at the earliest in the cycle after the response.

## Test plan
- **Round-robin fairness.** All three requesters valid continuously (reads), mem_req_ready_i = 1, responses returned 2 cycles after issue. Required: mem_req_tid_o order 0,1,2,3 …; grant source order 0,1,2,0,1,2.
- **Backpressure.** Requester 1 accepted, then mem_req_ready_i = 0 for 5 cycles. Required:
  - mem_req_addr_o/tid stable for 5 cycles;
  - req_ready_o = 0 for all;
  - the new request issues in the cycle after ready returns.
- **ID exhaustion.** 4 reads issued, no responses. Required: req_ready_o = 0. Then a response with tid 2 arrives in cycle N. Required:
  - rsp_valid_o routes to the source recorded for tid 2 in cycle N;
  - the next grant occurs in cycle N+1 with mem_req_tid_o = 2.
- **Write cap.** MaxWrOutstanding = 3 override, TidWidth = 3. Requester 2 issues 3 writes. Required:
  - a 4th write is blocked while requester 0 reads still get granted;
  - a write response in cycle N unblocks the write, so it is accepted in N+1.
- **Spurious response.** Response with tid 1 while ID 1 is free. Required: spurious_rsp_o = 1 for 1 cycle, rsp_valid_o = 0, no ID state change.
- **Reset mid-operation.** Assert rst_ni = 0 with 3 IDs busy and mem_req_valid_o = 1. Required:
  - all outputs at reset values immediately (asynchronous);
  - after release, first grant uses tid 0 and source 0 if requester 0 is valid.
